// File: rtl/exe_stage_pipe.sv
// exe_stage_pipe: pipelined ARM execute stage with its own EX/MEM output register.
// It has a valid/ready handshake on both sides and N-way operand forwarding.
// An iterative MUL/MLA unit retires MUL_BITS multiplier bits per cycle and
// holds the stage (in_ready=0) until the result is written.
// Optional build macro: MUL_EARLY_TERM_EN. When it is defined, a multiply
// finishes as soon as the remaining multiplier bits are all zero. The result
// is the same in both builds.
module exe_stage_pipe #(
  parameter int WORD_LENGTH = 32,
  parameter int FWD_SRCS    = 2,
  parameter int MUL_BITS    = 4,
  localparam int FS         = $clog2(FWD_SRCS + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic                            out_valid,
  input  logic                            out_ready,
  input  logic                            flush,
  input  logic                            wb_en_in,
  input  logic                            mem_r_en_in,
  input  logic                            mem_w_en_in,
  input  logic                            status_w_en_in,
  input  logic                            branch_taken_in,
  input  logic                            immd,
  input  logic                            is_mul,
  input  logic                            mul_acc,
  input  logic [WORD_LENGTH-1:0]          pc_in,
  input  logic [WORD_LENGTH-1:0]          val_Rn,
  input  logic [WORD_LENGTH-1:0]          val_Rm_in,
  input  logic [WORD_LENGTH-1:0]          val_Rs,
  input  logic [3:0]                      exe_cmd,
  input  logic [3:0]                      dest_in,
  input  logic [23:0]                     signed_immd_24,
  input  logic [11:0]                     shift_operand,
  input  logic [3:0]                      status_reg_in,
  input  logic [FS-1:0]                   fwd_sel_src1,
  input  logic [FS-1:0]                   fwd_sel_src2,
  input  logic [FWD_SRCS*WORD_LENGTH-1:0] fwd_values,
  output logic                            wb_en_out,
  output logic                            mem_r_en_out,
  output logic                            mem_w_en_out,
  output logic                            status_w_en_out,
  output logic                            branch_taken_out,
  output logic [3:0]                      dest_out,
  output logic [WORD_LENGTH-1:0]          alu_res,
  output logic [WORD_LENGTH-1:0]          val_Rm_out,
  output logic [WORD_LENGTH-1:0]          branch_address,
  output logic [3:0]                      status_register
);

  localparam int W     = WORD_LENGTH;
  localparam int STEPS = WORD_LENGTH / MUL_BITS;
  localparam int CW    = $clog2(STEPS + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(STEPS);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_HOLD = 2'b10
  } state_t;

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         v;
  } alu_out_t;

  // Operand select: 0 and out-of-range selectors keep the register value.
  function automatic logic [W-1:0] fwd_pick(input logic [FS-1:0] sel,
                                            input logic [W-1:0] reg_val,
                                            input logic [FWD_SRCS*W-1:0] vals);
    logic [W-1:0] r;
    r = reg_val;
    for (int k = 0; k < FWD_SRCS; k++) begin
      if (int'(sel) == k + 1) begin
        r = vals[k*W +: W];
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] ror_f(input logic [W-1:0] x, input logic [4:0] amt);
    logic [W-1:0] r;
    if (amt == 5'd0) begin
      r = x;
    end else begin
      r = (x >> amt) | (x << (W - int'(amt)));
    end
    return r;
  endfunction

  // Second ALU operand: memory offset, rotated immediate, or shifted register.
  function automatic logic [W-1:0] val2_f(input logic [W-1:0] rm, input logic [11:0] op,
                                          input logic is_imm, input logic is_mem);
    logic [W-1:0] r;
    if (is_mem) begin
      r = {{(W-12){1'b0}}, op};
    end else if (is_imm) begin
      r = ror_f({{(W-8){1'b0}}, op[7:0]}, {op[11:8], 1'b0});
    end else begin
      case (op[6:5])
        2'b00:   r = rm << op[11:7];
        2'b01:   r = rm >> op[11:7];
        2'b10:   r = $signed(rm) >>> op[11:7];
        2'b11:   r = ror_f(rm, op[11:7]);
        default: r = rm;
      endcase
    end
    return r;
  endfunction

  // ARM ALU: C is "no borrow" for subtraction. Logical ops keep the incoming C/V.
  function automatic alu_out_t alu_f(input logic [3:0] cmd, input logic [W-1:0] a,
                                     input logic [W-1:0] b, input logic [3:0] st);
    alu_out_t     o;
    logic [W:0]   sum;
    logic [W-1:0] b_eff;
    logic         ci;
    logic         arith;
    o.res = {W{1'b0}};
    o.c   = st[2];
    o.v   = st[0];
    b_eff = b;
    ci    = 1'b0;
    arith = 1'b0;
    case (cmd)
      4'b0001: o.res = b;
      4'b1001: o.res = ~b;
      4'b0010: arith = 1'b1;
      4'b0011: begin arith = 1'b1; ci = st[2]; end
      4'b0100: begin arith = 1'b1; b_eff = ~b; ci = 1'b1; end
      4'b0101: begin arith = 1'b1; b_eff = ~b; ci = st[2]; end
      4'b0110: o.res = a & b;
      4'b0111: o.res = a | b;
      4'b1000: o.res = a ^ b;
      default: o.res = {W{1'b0}};
    endcase
    sum = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, ci};
    if (arith) begin
      o.res = sum[W-1:0];
      o.c   = sum[W];
      o.v   = (a[W-1] == b_eff[W-1]) & (sum[W-1] != a[W-1]);
    end
    return o;
  endfunction

  state_t       state_r, state_nxt_s;
  logic [W-1:0] mcand_r, mplier_r, prod_r, acc_r;
  logic [CW-1:0] cnt_r;
  logic [1:0]   cv_r;
  logic         out_valid_r, wb_en_r, mem_r_en_r, mem_w_en_r, status_w_en_r, branch_taken_r;
  logic [3:0]   dest_r, status_r;
  logic [W-1:0] alu_res_r, val_rm_r, br_addr_r;

  logic [W-1:0] src1_s, src2_s, val2_s, br_addr_s, term_s, prod_nxt_s, fin_res_s;
  alu_out_t     alu_s;
  logic         out_free_s, accept_s, last_s, finish_s;

  assign out_free_s = ~out_valid_r | out_ready;
  assign in_ready   = (state_r == ST_IDLE) & out_free_s;
  assign accept_s   = in_valid & in_ready & ~flush;

  assign src1_s    = fwd_pick(fwd_sel_src1, val_Rn, fwd_values);
  assign src2_s    = fwd_pick(fwd_sel_src2, val_Rm_in, fwd_values);
  assign val2_s    = val2_f(src2_s, shift_operand, immd, mem_r_en_in | mem_w_en_in);
  assign alu_s     = alu_f(exe_cmd, src1_s, val2_s, status_reg_in);
  assign br_addr_s = pc_in + {{(W-26){signed_immd_24[23]}}, signed_immd_24, 2'b00};

  assign term_s     = mcand_r * {{(W-MUL_BITS){1'b0}}, mplier_r[MUL_BITS-1:0]};
  assign prod_nxt_s = prod_r + term_s;

  // Last multiply step: counter exhausted, or (early-term build) no multiplier bits left.
  always_comb begin
    last_s = 1'b0;
`ifdef MUL_EARLY_TERM_EN
    last_s = (cnt_r == CNT_ONE) | (mplier_r[W-1:MUL_BITS] == {(W-MUL_BITS){1'b0}});
`else
    last_s = (cnt_r == CNT_ONE);
`endif
  end

  // Multiply result and the condition under which it goes into the output register.
  always_comb begin
    fin_res_s = {W{1'b0}};
    finish_s  = 1'b0;
    if (state_r == ST_HOLD) begin
      fin_res_s = prod_r + acc_r;
      finish_s  = out_free_s & ~flush;
    end else if (state_r == ST_MUL) begin
      fin_res_s = prod_nxt_s + acc_r;
      finish_s  = last_s & out_free_s & ~flush;
    end else begin
      fin_res_s = {W{1'b0}};
      finish_s  = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state. Flush always returns to IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && is_mul) begin
          state_nxt_s = ST_MUL;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (flush) begin
          state_nxt_s = ST_IDLE;
        end else if (last_s) begin
          state_nxt_s = out_free_s ? ST_IDLE : ST_HOLD;
        end else begin
          state_nxt_s = ST_MUL;
        end
      end
      ST_HOLD: begin
        if (flush || out_free_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Iterative multiplier: operand capture at accept, then one digit per cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_r  <= {W{1'b0}};
      mplier_r <= {W{1'b0}};
      prod_r   <= {W{1'b0}};
      acc_r    <= {W{1'b0}};
      cnt_r    <= CNT_ZERO;
      cv_r     <= 2'b00;
    end else if (flush) begin
      mplier_r <= {W{1'b0}};
      prod_r   <= {W{1'b0}};
      cnt_r    <= CNT_ZERO;
    end else if (accept_s && is_mul) begin
      mcand_r  <= src1_s;
      mplier_r <= val_Rs;
      prod_r   <= {W{1'b0}};
      acc_r    <= mul_acc ? src2_s : {W{1'b0}};
      cnt_r    <= CNT_LOAD;
      cv_r     <= {status_reg_in[2], status_reg_in[0]};
    end else if (state_r == ST_MUL) begin
      prod_r <= prod_nxt_s;
      if (last_s) begin
        cnt_r <= CNT_ZERO;
      end else begin
        mcand_r  <= mcand_r << MUL_BITS;
        mplier_r <= mplier_r >> MUL_BITS;
        cnt_r    <= cnt_r - CNT_ONE;
      end
    end
  end

  // EX/MEM output register. It holds while out_valid is set and out_ready is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_r    <= 1'b0;
      wb_en_r        <= 1'b0;
      mem_r_en_r     <= 1'b0;
      mem_w_en_r     <= 1'b0;
      status_w_en_r  <= 1'b0;
      branch_taken_r <= 1'b0;
      dest_r         <= 4'd0;
      status_r       <= 4'd0;
      alu_res_r      <= {W{1'b0}};
      val_rm_r       <= {W{1'b0}};
      br_addr_r      <= {W{1'b0}};
    end else if (flush) begin
      out_valid_r <= 1'b0;
    end else if (accept_s) begin
      // Controls for a multiply are parked here; the result follows later.
      out_valid_r    <= ~is_mul;
      wb_en_r        <= wb_en_in;
      mem_r_en_r     <= mem_r_en_in;
      mem_w_en_r     <= mem_w_en_in;
      status_w_en_r  <= status_w_en_in;
      branch_taken_r <= branch_taken_in;
      dest_r         <= dest_in;
      val_rm_r       <= src2_s;
      br_addr_r      <= br_addr_s;
      if (!is_mul) begin
        alu_res_r <= alu_s.res;
        status_r  <= {alu_s.res[W-1], alu_s.c, (alu_s.res == {W{1'b0}}), alu_s.v};
      end
    end else if (finish_s) begin
      out_valid_r <= 1'b1;
      alu_res_r   <= fin_res_s;
      status_r    <= {fin_res_s[W-1], cv_r[1], (fin_res_s == {W{1'b0}}), cv_r[0]};
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign out_valid        = out_valid_r;
  assign wb_en_out        = wb_en_r;
  assign mem_r_en_out     = mem_r_en_r;
  assign mem_w_en_out     = mem_w_en_r;
  assign status_w_en_out  = status_w_en_r;
  assign branch_taken_out = branch_taken_r;
  assign dest_out         = dest_r;
  assign alu_res          = alu_res_r;
  assign val_Rm_out       = val_rm_r;
  assign branch_address   = br_addr_r;
  assign status_register  = status_r;

endmodule
